// File: rtl/branch_resolve.sv
// branch_resolve: two-stage elastic branch-resolution pipeline.
//   S1 registers the operands, PC, offset, branch type and prediction; the
//   comparator is driven from those registers. S2 registers the resolved
//   direction, redirect PC, misprediction and illegal-type flags, and those
//   registers drive the outputs directly.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   Flush                synchronous kill of both stages
//   InValid/InReady      upstream handshake
//   Funct3, A, B, PC,    branch type, rs1/rs2, branch PC,
//   Imm, PredTaken       sign-extended offset, fetch prediction
//   OutValid/OutReady    downstream handshake
//   Taken, NextPC,       resolved direction, redirect PC,
//   Mispredict, Illegal  prediction miss, reserved funct3 flag

// Comparator for branch conditions: equality, signed and unsigned less-than.
module branch_resolve_cmp #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

module branch_resolve #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] PC,
  input  logic [WIDTH-1:0] Imm,
  input  logic             PredTaken,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Taken,
  output logic [WIDTH-1:0] NextPC,
  output logic             Mispredict,
  output logic             Illegal
);

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

  // Stage 1 state
  logic             v1_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] imm_r;
  logic [2:0]       funct3_r;
  logic             pred_r;

  // Stage 2 state (drives the outputs)
  logic             v2_r;
  logic             taken_r;
  logic [WIDTH-1:0] nextpc_r;
  logic             mispredict_r;
  logic             illegal_r;

  // Handshake and datapath intermediates
  logic             advance1_s;
  logic             accept_s;
  logic             drain_s;
  logic             eq_s;
  logic             lt_s;
  logic             ltu_s;
  logic             taken_s;
  logic             illegal_s;
  logic             mispredict_s;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] seq_pc_s;
  logic [WIDTH-1:0] nextpc_s;

  // S1 can move on whenever S2 is empty or is being drained this cycle.
  assign advance1_s = v1_r & (~v2_r | OutReady);
  assign InReady    = ~v1_r | advance1_s;
  assign accept_s   = InValid & InReady;
  assign drain_s    = v2_r & OutReady;

  branch_resolve_cmp #(.WIDTH(WIDTH)) u_cmp (
    .a   (a_r),
    .b   (b_r),
    .eq  (eq_s),
    .lt  (lt_s),
    .ltu (ltu_s)
  );

  // Decode the branch condition from the registered funct3.
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (funct3_r)
      3'b000:         taken_s   = eq_s;
      3'b001:         taken_s   = ~eq_s;
      3'b100:         taken_s   = lt_s;
      3'b101:         taken_s   = ~lt_s;
      3'b110:         taken_s   = ltu_s;
      3'b111:         taken_s   = ~ltu_s;
      3'b010, 3'b011: illegal_s = 1'b1;
      default: begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
      end
    endcase
  end

  // Redirect target and fall-through PC both wrap modulo 2^WIDTH.
  always_comb begin
    target_s     = pc_r + imm_r;
    seq_pc_s     = pc_r + PC_STEP;
    mispredict_s = ~illegal_s & (taken_s ^ pred_r);
    if (taken_s) begin
      nextpc_s = target_s;
    end else begin
      nextpc_s = seq_pc_s;
    end
  end

  // Stage 1 valid: flush wins over accept, accept wins over a plain advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r <= 1'b0;
    end else if (Flush) begin
      v1_r <= 1'b0;
    end else if (accept_s) begin
      v1_r <= 1'b1;
    end else if (advance1_s) begin
      v1_r <= 1'b0;
    end
  end

  // Stage 1 payload capture on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      pc_r     <= {WIDTH{1'b0}};
      imm_r    <= {WIDTH{1'b0}};
      funct3_r <= 3'b000;
      pred_r   <= 1'b0;
    end else if (accept_s && !Flush) begin
      a_r      <= A;
      b_r      <= B;
      pc_r     <= PC;
      imm_r    <= Imm;
      funct3_r <= Funct3;
      pred_r   <= PredTaken;
    end
  end

  // Stage 2 valid: refilled by an S1 advance, emptied by a drain or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_r <= 1'b0;
    end else if (Flush) begin
      v2_r <= 1'b0;
    end else if (advance1_s) begin
      v2_r <= 1'b1;
    end else if (drain_s) begin
      v2_r <= 1'b0;
    end
  end

  // Stage 2 result capture; held unchanged while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_r      <= 1'b0;
      nextpc_r     <= {WIDTH{1'b0}};
      mispredict_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else if (advance1_s && !Flush) begin
      taken_r      <= taken_s;
      nextpc_r     <= nextpc_s;
      mispredict_r <= mispredict_s;
      illegal_r    <= illegal_s;
    end
  end

  assign OutValid   = v2_r;
  assign Taken      = taken_r;
  assign NextPC     = nextpc_r;
  assign Mispredict = mispredict_r;
  assign Illegal    = illegal_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (WIDTH = 64).
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [2:0]  Funct3;
  logic [63:0] A;
  logic [63:0] B;
  logic [63:0] PC;
  logic [63:0] Imm;
  logic        PredTaken;
  logic        OutValid;
  logic        OutReady;
  logic        Taken;
  logic [63:0] NextPC;
  logic        Mispredict;
  logic        Illegal;

  int tests = 0;
  int fails = 0;

  branch_resolve #(.WIDTH(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .Flush      (Flush),
    .InValid    (InValid),
    .InReady    (InReady),
    .Funct3     (Funct3),
    .A          (A),
    .B          (B),
    .PC         (PC),
    .Imm        (Imm),
    .PredTaken  (PredTaken),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Taken      (Taken),
    .NextPC     (NextPC),
    .Mispredict (Mispredict),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  // Present one branch to an empty pipeline with OutReady high and return
  // #1 after the edge at which its result lands in S2.
  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] imm, input logic p);
    @(posedge clk); #1;
    OutReady = 1'b1; InValid = 1'b1;
    Funct3 = f; A = a; B = b; PC = pc; Imm = imm; PredTaken = p;
    @(posedge clk); #1;
    InValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || Taken !== 1'b0 || NextPC !== 64'h0 ||
        Mispredict !== 1'b0 || Illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: OutValid=%b InReady=%b Taken=%b NextPC=%h Mis=%b Ill=%b, required 0 1 0 0 0 0",
               OutValid, InReady, Taken, NextPC, Mispredict, Illegal);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: OutValid=%b InReady=%b, required 0 1", OutValid, InReady);
    end
  endtask

  task automatic test_beq();
    issue(3'b000, 64'h1234, 64'h1234, 64'h1000, 64'h40, 1'b0);
    tests++;
    if (OutValid !== 1'b1 || Taken !== 1'b1 || NextPC !== 64'h1040 ||
        Mispredict !== 1'b1 || Illegal !== 1'b0) begin
      fails++;
      $display("FAIL beq: V=%b T=%b NextPC=%h M=%b I=%b, required 1 1 1040 1 0",
               OutValid, Taken, NextPC, Mispredict, Illegal);
    end
  endtask

  task automatic test_signed_unsigned();
    logic [2:0]  f_t   [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
    logic        p_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        tk_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        mis_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] npc_t [4] = '{64'h2100, 64'h2004, 64'h2004, 64'h2100};
    for (int i = 0; i < 4; i++) begin
      issue(f_t[i], 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2000, 64'h100, p_t[i]);
      tests++;
      if (OutValid !== 1'b1 || Taken !== tk_t[i] || NextPC !== npc_t[i] ||
          Mispredict !== mis_t[i] || Illegal !== 1'b0) begin
        fails++;
        $display("FAIL cmp_f3_%b: V=%b T=%b NextPC=%h M=%b I=%b, required 1 %b %h %b 0",
                 f_t[i], OutValid, Taken, NextPC, Mispredict, Illegal, tk_t[i], npc_t[i], mis_t[i]);
      end
    end
  endtask

  task automatic test_wrap();
    issue(3'b001, 64'h55, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 64'h40, 1'b0);
    tests++;
    if (Taken !== 1'b0 || NextPC !== 64'h0) begin
      fails++;
      $display("FAIL wrap_seq: T=%b NextPC=%h, required 0 0", Taken, NextPC);
    end
    issue(3'b000, 64'h55, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 1'b1);
    tests++;
    if (Taken !== 1'b1 || NextPC !== 64'h4 || Mispredict !== 1'b0) begin
      fails++;
      $display("FAIL wrap_target: T=%b NextPC=%h M=%b, required 1 4 0", Taken, NextPC, Mispredict);
    end
  endtask

  task automatic test_illegal();
    issue(3'b010, 64'h7, 64'h7, 64'h3000, 64'h80, 1'b1);
    tests++;
    if (OutValid !== 1'b1 || Illegal !== 1'b1 || Taken !== 1'b0 ||
        Mispredict !== 1'b0 || NextPC !== 64'h3004) begin
      fails++;
      $display("FAIL illegal: V=%b I=%b T=%b M=%b NextPC=%h, required 1 1 0 0 3004",
               OutValid, Illegal, Taken, Mispredict, NextPC);
    end
  endtask

  // Four branches, OutReady low for the first three cycles; even entries are
  // taken BEQs, odd entries not-taken BNEs.
  task automatic test_back_pressure();
    logic [63:0] exp_t [4] = '{64'h4010, 64'h4104, 64'h4210, 64'h4304};
    int sent = 0;
    int recv = 0;
    logic rdy;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      OutReady  = (cyc >= 3);
      InValid   = (sent < 4);
      Funct3    = (sent % 2 == 0) ? 3'b000 : 3'b001;
      A         = 64'h9;
      B         = 64'h9;
      PC        = 64'h4000 + 64'(sent) * 64'h100;
      Imm       = 64'h10;
      PredTaken = 1'b0;
      #1;
      rdy = InReady;
      if (cyc == 2) begin
        tests++;
        if (rdy !== 1'b0 || sent != 2) begin
          fails++;
          $display("FAIL bp_inready_drop: InReady=%b accepts=%0d, required 0 2", rdy, sent);
        end
      end
      if (OutValid === 1'b1 && recv < 4) begin
        tests++;
        if (NextPC !== exp_t[recv]) begin
          fails++;
          $display("FAIL bp_order_%0d: NextPC=%h, required %h (OutReady=%b)", recv, NextPC, exp_t[recv], OutReady);
        end
        if (OutReady) recv++;
      end else if (OutValid === 1'b1) begin
        tests++;
        fails++;
        $display("FAIL bp_extra: NextPC=%h after all 4 results, required none", NextPC);
      end
      @(negedge clk);
      if (InValid && rdy) sent++;
    end
    InValid = 1'b0;
    tests++;
    if (sent != 4 || recv != 4) begin
      fails++;
      $display("FAIL bp_count: accepted=%0d emerged=%0d, required 4 4", sent, recv);
    end
  endtask

  task automatic test_flush();
    logic seen;
    @(posedge clk); #1;
    OutReady = 1'b0; InValid = 1'b1;
    Funct3 = 3'b000; A = 64'h1; B = 64'h1; PC = 64'h5000; Imm = 64'h20; PredTaken = 1'b0;
    @(posedge clk); #1;
    InValid = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (OutValid !== 1'b1 || NextPC !== 64'h5020) begin
      fails++;
      $display("FAIL flush_setup: V=%b NextPC=%h, required 1 5020", OutValid, NextPC);
    end
    InValid = 1'b1; Flush = 1'b1; PC = 64'h6000;
    #1;
    tests++;
    if (InReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_inready: InReady=%b, required 1", InReady);
    end
    @(posedge clk); #1;
    Flush = 1'b0; InValid = 1'b0;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1) begin
      fails++;
      $display("FAIL flush_clear: V=%b InReady=%b, required 0 1", OutValid, InReady);
    end
    OutReady = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (OutValid !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_dropped: an output emerged after flush, required none");
    end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    OutReady = 1'b1; InValid = 1'b1;
    Funct3 = 3'b000; A = 64'h3; B = 64'h3; PC = 64'h7000; Imm = 64'h8; PredTaken = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (OutValid !== 1'b1 || NextPC !== 64'h7008) begin
      fails++;
      $display("FAIL rst_mid_setup: V=%b NextPC=%h, required 1 7008", OutValid, NextPC);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if (OutValid !== 1'b0 || InReady !== 1'b1 || NextPC !== 64'h0 || Taken !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: V=%b InReady=%b NextPC=%h T=%b, required 0 1 0 0",
               OutValid, InReady, NextPC, Taken);
    end
    InValid = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (OutValid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_after: V=%b, required 0", OutValid);
    end
  endtask

  initial begin
    Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    Funct3 = 3'b000; A = 64'h0; B = 64'h0; PC = 64'h0; Imm = 64'h0; PredTaken = 1'b0;
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wrap();
    test_illegal();
    test_back_pressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Two-stage elastic pipeline that resolves conditional branches for the integer datapath. It registers the operands and branch type, and takes EQ/LT/LTu from an instance of the parameterized comparator tree on the registered operands. It decodes the funct3 condition, computes the redirect target, and flags mispredictions against the fetch-stage prediction. It sits directly downstream of the comparator tree, between operand read and the fetch redirect logic.

## Interface
- WIDTH, 64, operand/PC width; power of two, ≥ 8 (comparator tree constraint).
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- Flush  input  1  synchronous kill of all in-flight entries.
- InValid  input  1  upstream presents a branch.
- InReady  output  1  block accepts this cycle.
- Funct3  input  3  branch type.
- A, B  input  WIDTH  rs1, rs2 operands.
- PC  input  WIDTH  branch PC.
- Imm  input  WIDTH  sign-extended branch offset.
- PredTaken  input  1  fetch-stage prediction.
- OutValid  output  1  result valid.
- OutReady  input  1  downstream accepts.
- Taken  output  1  resolved direction.
- NextPC  output  WIDTH  Target if Taken, else PC+4.
- Mispredict  output  1  Taken ≠ PredTaken (legal types only).
- Illegal  output  1  Funct3 is 010 or 011.

## Operation
- Stage 1 (S1): on accept (InValid & InReady), capture A, B, PC, Imm, Funct3, PredTaken and set V1.
- The comparator tree is driven from the S1 operand registers.
- Stage 2 (S2): on S1→S2 advance, capture Taken, NextPC, Mispredict, Illegal and set V2.
- The S2 registers drive the outputs directly.
- Funct3 decode:
  - 000: Taken = EQ.
  - 001: Taken = ~EQ.
  - 100: Taken = LT.
  - 101: Taken = ~LT.
  - 110: Taken = LTu.
  - 111: Taken = ~LTu.
  - 010, 011: Illegal = 1, Taken = 0, Mispredict = 0.
- Arithmetic: Target = PC + Imm, modulo 2^WIDTH, with carry discarded. PC+4 also wraps modulo 2^WIDTH.
- Handshake control:
  - S2 holds when V2 & ~OutReady.
  - S1 advances when V1 & (~V2 | OutReady).
  - InReady = ~V1 | advance1. Full throughput: one branch per cycle when OutReady stays high.
  - Outputs are stable while OutValid & ~OutReady.
  - InValid must not depend on InReady.
- Flush:
  - Clears V1 and V2 at the next edge.
  - Overrides any simultaneous accept or advance; the flushed input is dropped.
  - InReady is not gated by Flush.
- Simultaneous events: when S2 drains and S1 advances in the same cycle, S2 loads the new result with no bubble. When S1 advances and a new input is accepted in the same cycle, both happen.

## Timing
- Latency: accept at edge n; OutValid = 1 after edge n+1, with the result visible in the cycle between edges n+1 and n+2.
- InReady is combinational from V1, V2 and OutReady. There is no combinational path from any data input to any output.
- Reset (asynchronous assert, synchronous-safe release):
  - V1 = V2 = 0.
  - OutValid, Taken, Mispredict, Illegal = 0; NextPC = 0.
  - InReady = 1 during and after reset.
- Reset asserted mid-operation discards all in-flight entries immediately; no output handshake completes.
- Data registers need not be cleared except the output-visible S2 set listed above.

## Test plan
- BEQ, A = B = 0x0000_0000_0000_1234, PC = 0x1000, Imm = 0x40, PredTaken = 0 -> two cycles later: Taken = 1, NextPC = 0x1040, Mispredict = 1, Illegal = 0.
- Signed vs unsigned, A = 0xFFFF_FFFF_FFFF_FFFF (−1), B = 1, PC = 0x2000:
  - BLT -> Taken = 1.
  - BLTU -> Taken = 0, NextPC = 0x2004.
  - BGE -> Taken = 0.
  - BGEU -> Taken = 1.
- Wrap-around: PC = 0xFFFF_FFFF_FFFF_FFFC with not-taken BNE (A = B) -> NextPC = 0. The same PC with Imm = 8 and taken -> NextPC = 4.
- Back-pressure: stream 4 branches with OutReady low for 3 cycles:
  - InReady drops after 2 accepts.
  - Outputs hold stable.
  - After OutReady rises, all 4 results emerge in order with no loss or duplication.
- Funct3 = 010 with PredTaken = 1 -> Illegal = 1, Taken = 0, Mispredict = 0, NextPC = PC+4.
- Flush asserted in the same cycle as an accept, with one entry in S2 -> next cycle OutValid = 0 and nothing emerges. Separately, reset_n pulsed low mid-stream -> OutValid = 0 immediately and InReady = 1.
